adc_sample_sequencer: RTL and testbench

ADC_SAMPLE_SEQUENCER -- requirements
Module: adc_sample_sequencer

---
 rtl/adc_sample_sequencer.sv | 170 +++++++++++++++++
 tb/tb_adc_sample_sequencer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_sample_sequencer.sv
// Periodic multi-channel ADC sweep sequencer: on each sample tick, converts every enabled
// channel in ascending order over an SPI front end and hands samples downstream.
module adc_sample_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 2048,
    parameter int unsigned NUM_CH         = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic [15:0]                period,
    input  logic [NUM_CH-1:0]          chan_mask,
    input  logic                       err_clr,
    output logic                       spi_start,
    input  logic                       spi_busy,
    input  logic                       spi_done,
    input  logic [11:0]                spi_data,
    output logic [$clog2(NUM_CH)-1:0]  chan_sel,
    output logic [11:0]                sample_data,
    output logic [$clog2(NUM_CH)-1:0]  sample_chan,
    output logic                       sample_valid,
    input  logic                       sample_ready,
    output logic                       overrun,
    output logic                       timeout_err
);

    localparam int unsigned CHW = $clog2(NUM_CH);
    localparam int unsigned TW  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {StIdle, StWaitTick, StStart, StWaitDone, StOutput} state_t;

    state_t            state_q, state_d;
    logic [15:0]       tick_cnt_q, period_eff;
    logic              tick;
    logic [NUM_CH-1:0] mask_q, mask_d;
    logic [CHW-1:0]    chan_q, chan_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic [11:0]       data_q, data_d;
    logic [CHW-1:0]    schan_q, schan_d;
    logic              valid_q, valid_d;
    logic              overrun_q, overrun_d;
    logic              tmo_err_q, tmo_err_d;
    logic [CHW:0]      first_pick, next_pick;

    // Returns {found, index} of the lowest set bit of m at or above position from.
    function automatic logic [CHW:0] first_set(input logic [NUM_CH-1:0] m, input int from);
        logic [CHW:0] r;
        r = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (m[i] && i >= from) r = {1'b1, CHW'(i)};
        end
        return r;
    endfunction

    assign period_eff = (period < 16'd2) ? 16'd2 : period;
    // >= keeps the counter from running off if period shrinks mid-count.
    assign tick       = enable && (tick_cnt_q >= period_eff - 16'd1);
    assign first_pick = first_set(chan_mask, 0);
    assign next_pick  = first_set(mask_q, int'(chan_q) + 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt_q <= '0;
        end else if (!enable || tick) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_q + 16'd1;
        end
    end

    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        chan_d    = chan_q;
        tmo_d     = tmo_q;
        data_d    = data_q;
        schan_d   = schan_q;
        valid_d   = valid_q;
        spi_start = 1'b0;
        overrun_d = overrun_q & ~err_clr;
        tmo_err_d = tmo_err_q & ~err_clr;

        if (tick && (state_q == StStart || state_q == StWaitDone || state_q == StOutput)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            StIdle: begin
                if (enable) state_d = StWaitTick;
            end
            StWaitTick: begin
                if (!enable) begin
                    state_d = StIdle;
                end else if (tick) begin
                    mask_d = chan_mask;
                    if (first_pick[CHW]) begin
                        chan_d  = first_pick[CHW-1:0];
                        state_d = StStart;
                    end
                end
            end
            StStart: begin
                if (!enable) begin
                    state_d = StIdle;
                end else if (!spi_busy) begin
                    spi_start = 1'b1;
                    tmo_d     = '0;
                    state_d   = StWaitDone;
                end
            end
            StWaitDone: begin
                tmo_d = tmo_q + TW'(1);
                if (spi_done) begin
                    data_d  = spi_data;
                    schan_d = chan_q;
                    valid_d = 1'b1;
                    state_d = StOutput;
                end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    tmo_err_d = 1'b1;
                    state_d   = enable ? StWaitTick : StIdle;
                end
            end
            StOutput: begin
                if (sample_ready) begin
                    valid_d = 1'b0;
                    if (!enable) begin
                        state_d = StIdle;
                    end else if (next_pick[CHW]) begin
                        chan_d  = next_pick[CHW-1:0];
                        state_d = StStart;
                    end else begin
                        state_d = StWaitTick;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            mask_q    <= '0;
            chan_q    <= '0;
            tmo_q     <= '0;
            data_q    <= '0;
            schan_q   <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            tmo_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            chan_q    <= chan_d;
            tmo_q     <= tmo_d;
            data_q    <= data_d;
            schan_q   <= schan_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            tmo_err_q <= tmo_err_d;
        end
    end

    assign chan_sel     = chan_q;
    assign sample_data  = data_q;
    assign sample_chan  = schan_q;
    assign sample_valid = valid_q;
    assign overrun      = overrun_q;
    assign timeout_err  = tmo_err_q;

endmodule

// File: tb/tb_adc_sample_sequencer.sv
// Bench for adc_sample_sequencer: the bench plays the SPI front end and the downstream sink,
// predicting sweep timing and per-channel sample order from the tick period and latched mask.
module tb_adc_sample_sequencer;

    localparam int TMO = 2048;

    logic        clk = 1'b0;
    logic        rst, enable, err_clr, spi_busy, spi_done, sample_ready;
    logic [15:0] period;
    logic [3:0]  chan_mask;
    logic [11:0] spi_data;
    logic        spi_start, sample_valid, overrun, timeout_err;
    logic [1:0]  chan_sel, sample_chan;
    logic [11:0] sample_data;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    adc_sample_sequencer #(.TIMEOUT_CYCLES(TMO), .NUM_CH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .period       (period),
        .chan_mask    (chan_mask),
        .err_clr      (err_clr),
        .spi_start    (spi_start),
        .spi_busy     (spi_busy),
        .spi_done     (spi_done),
        .spi_data     (spi_data),
        .chan_sel     (chan_sel),
        .sample_data  (sample_data),
        .sample_chan  (sample_chan),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .overrun      (overrun),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish, observed hang expected completion");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Returns the cycle of the next spi_start pulse, or -1 if none within budget.
    task automatic wait_start(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (spi_start === 1'b1) begin
                at = cyc;
                break;
            end
        end
    endtask

    // Entered at the negedge where spi_start is high; leaves one cycle after acceptance.
    task automatic do_frame(input logic [1:0] ch, input int lat, input logic [11:0] d,
                            input int hold);
        chk("chan_sel_at_start", chan_sel, ch);
        sample_ready = (hold == 0);
        for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            if (i == 0) chk("start_pulse_width", spi_start, 0);
        end
        chk("chan_sel_stable", chan_sel, ch);
        spi_done = 1'b1;
        spi_data = d;
        @(negedge clk);
        spi_done = 1'b0;
        spi_data = 12'($urandom);
        chk("sample_out", {spi_start, sample_valid, sample_chan, sample_data}, {1'b0, 1'b1, ch, d});
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("sample_hold", {spi_start, sample_valid, sample_chan, sample_data},
                {1'b0, 1'b1, ch, d});
        end
        sample_ready = 1'b1;
        @(negedge clk);
        chk("valid_drop", sample_valid, 0);
    endtask

    // One sweep over the set bits of m (the mask latched at its tick), expected at exp_start.
    task automatic run_sweep(input logic [3:0] m, input int exp_start, input int hold_first,
                             input int lat_fix, input bit data_fix, input logic [3:0] new_mask);
        int          at;
        int          lat;
        bit          first;
        logic [11:0] d;
        first = 1'b1;
        wait_start(exp_start - cyc + 10, at);
        chk("sweep_start_cycle", at, exp_start);
        chan_mask = new_mask;
        for (int ch = 0; ch < 4; ch++) begin
            if (m[ch]) begin
                if (!first) chk("next_chan_start", spi_start, 1);
                lat = (lat_fix > 0) ? lat_fix : int'($urandom_range(1, 20));
                d   = data_fix ? 12'hABC : 12'($urandom);
                do_frame(2'(ch), lat, d, first ? hold_first : 0);
                first = 1'b0;
            end
        end
        chk("sweep_end_idle", spi_start, 0);
    endtask

    initial begin
        int          t0, at, r, p;
        logic [3:0]  m0, m1;
        logic        seen;
        logic [11:0] d;

        rst = 1'b1; enable = 1'b0; period = 16'd100; chan_mask = 4'h0; err_clr = 1'b0;
        spi_busy = 1'b0; spi_done = 1'b0; spi_data = '0; sample_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {spi_start, chan_sel, sample_data, sample_chan, sample_valid,
                              overrun, timeout_err}, 0);
        rst = 1'b0;
        @(negedge clk);

        // Two channels, fixed data, 40-cycle frames, ticks 100 cycles apart.
        period = 16'd100; chan_mask = 4'b0101; enable = 1'b1; t0 = cyc + 100;
        run_sweep(4'b0101, t0, 0, 40, 1'b1, 4'b0101);
        run_sweep(4'b0101, t0 + 100, 0, 40, 1'b1, 4'b0101);
        chk("no_overrun_basic", overrun, 0);
        enable = 1'b0;
        @(negedge clk);

        // Random periods/masks; the mask changes mid-sweep and applies only to the next one.
        for (int it = 0; it < 3; it++) begin
            p  = int'($urandom_range(100, 200));
            m0 = 4'($urandom_range(1, 15));
            m1 = 4'($urandom_range(1, 15));
            period = 16'(p); chan_mask = m0; enable = 1'b1; t0 = cyc + p;
            run_sweep(m0, t0, 0, 0, 1'b0, m1);
            run_sweep(m1, t0 + p, 0, 0, 1'b0, m1);
            chk("no_overrun_random", overrun, 0);
            enable = 1'b0;
            @(negedge clk);
        end

        // Downstream stalls for 300 cycles on the first sample.
        period = 16'd1000; chan_mask = 4'b0011; enable = 1'b1; t0 = cyc + 1000;
        run_sweep(4'b0011, t0, 300, 0, 1'b0, 4'b0011);
        chk("no_overrun_stall", overrun, 0);
        enable = 1'b0;
        @(negedge clk);

        // spi_busy at the tick postpones spi_start until busy drops.
        period = 16'd120; chan_mask = 4'b0100; enable = 1'b1; t0 = cyc + 120;
        spi_busy = 1'b1;
        while (cyc < t0) @(negedge clk);
        chk("busy_blocks_start", spi_start, 0);
        repeat (5) @(negedge clk);
        chk("busy_still_blocks", spi_start, 0);
        spi_busy = 1'b0;
        #1;
        chk("start_after_busy", spi_start, 1);
        do_frame(2'd2, 10, 12'($urandom), 0);
        // Disable while held in START: no pulse at all.
        spi_busy = 1'b1;
        while (cyc < t0 + 120) @(negedge clk);
        chk("busy_blocks_start2", spi_start, 0);
        enable = 1'b0;
        @(negedge clk);
        spi_busy = 1'b0;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            seen = seen | spi_start;
        end
        chk("no_start_after_disable", seen, 0);

        // Period 50 with four 40-cycle frames: ticks land mid-sweep.
        period = 16'd50; chan_mask = 4'b1111; enable = 1'b1; t0 = cyc + 50;
        chk("overrun_clear_before", overrun, 0);
        run_sweep(4'b1111, t0, 0, 40, 1'b0, 4'b1111);
        enable = 1'b0;
        chk("overrun_set", overrun, 1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("overrun_cleared", overrun, 0);

        // Period 0 acts as 2; disable mid-frame delivers that sample then stops the sweep.
        period = 16'd0; chan_mask = 4'b0011; enable = 1'b1; t0 = cyc + 2;
        wait_start(12, at);
        chk("period0_start_cycle", at, t0);
        chk("period0_chan", chan_sel, 0);
        repeat (3) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        d = 12'($urandom);
        spi_done = 1'b1; spi_data = d;
        @(negedge clk);
        spi_done = 1'b0;
        chk("disable_sample", {spi_start, sample_valid, sample_chan, sample_data},
            {1'b0, 1'b1, 2'd0, d});
        @(negedge clk);
        chk("disable_valid_drop", sample_valid, 0);
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            seen = seen | spi_start;
        end
        chk("disable_skips_rest", seen, 0);
        chk("period0_overrun", overrun, 1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("period0_overrun_clr", overrun, 0);

        // spi_done never arrives: timeout abandons the sweep, next tick restarts at channel 1.
        period = 16'd3000; chan_mask = 4'b0110; enable = 1'b1; t0 = cyc + 3000;
        wait_start(3010, at);
        chk("tmo_start_cycle", at, t0);
        chk("tmo_chan", chan_sel, 1);
        while (cyc < t0 + TMO) @(negedge clk);
        chk("tmo_not_yet", timeout_err, 0);
        @(negedge clk);
        chk("tmo_set", timeout_err, 1);
        run_sweep(4'b0110, t0 + 3000, 0, 0, 1'b0, 4'b0110);
        chk("tmo_sticky", {overrun, timeout_err}, 2'b01);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("tmo_cleared", timeout_err, 0);
        enable = 1'b0;
        @(negedge clk);

        // Reset during WAIT_DONE clears outputs at once; a late spi_done is ignored.
        period = 16'd150; chan_mask = 4'b0100; enable = 1'b1; t0 = cyc + 150;
        wait_start(160, at);
        chk("rst_test_start", at, t0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("async_reset_outputs", {spi_start, chan_sel, sample_data, sample_chan, sample_valid,
                                    overrun, timeout_err}, 0);
        @(negedge clk);
        rst = 1'b0;
        r = cyc;
        @(negedge clk);
        spi_done = 1'b1; spi_data = 12'h5A5;
        @(negedge clk);
        spi_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("late_done_ignored", sample_valid, 0);
        run_sweep(4'b0100, r + 150, 0, 0, 1'b0, 4'b0100);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
